alu_unit: RTL and testbench

- 32-bit integer ALU for the single-cycle RV32I datapath.
- Executes add/sub, bitwise logic, shifts and set-less-than compares, selected by a 4-bit operation code.
- Result and status flags are captured in an output register (one-cycle latency), then consumed by the writeback and branch logic.

---
 rtl/alu_unit.sv | 118 +++++++++++
 tb/tb_alu_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: 32-bit integer ALU for the single-cycle RV32I datapath.
// Add/sub, bitwise logic, shifts and set-less-than compares. The result and
// its status flags are captured in an output register (one-cycle latency).
module alu_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    input  logic [3:0]         ALUoperation,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               negative,
    output logic               carry,
    output logic               overflow
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    // Sum/difference carry an extra bit so the carry-out falls out directly.
    logic [WIDTH:0]          add_s;
    logic [WIDTH:0]          sub_s;
    logic [SHAMT_W-1:0]      shamt_s;
    logic signed [WIDTH-1:0] sra_s;
    logic                    slt_s;
    logic                    sltu_s;
    logic [WIDTH-1:0]        res_s;
    logic                    carry_s;
    logic                    overflow_s;

    // Signed overflow of a+b: same-sign operands producing a different sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a-b: differing operand signs and result sign flips from a.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    // Shared datapath terms; compares use native comparators so they stay
    // correct when the subtraction itself overflows.
    always_comb begin
        add_s   = {1'b0, operand1} + {1'b0, operand2};
        sub_s   = {1'b0, operand1} + {1'b0, ~operand2} + {{WIDTH{1'b0}}, 1'b1};
        shamt_s = operand2[SHAMT_W-1:0];
        sra_s   = $signed(operand1) >>> shamt_s;
        slt_s   = $signed(operand1) < $signed(operand2);
        sltu_s  = operand1 < operand2;
    end

    // Opcode decode: select result and arithmetic flags; reserved codes give zeros.
    always_comb begin
        res_s      = {WIDTH{1'b0}};
        carry_s    = 1'b0;
        overflow_s = 1'b0;
        case (ALUoperation)
            OP_ADD: begin
                res_s      = add_s[WIDTH-1:0];
                carry_s    = add_s[WIDTH];
                overflow_s = add_ovf(operand1[WIDTH-1], operand2[WIDTH-1], add_s[WIDTH-1]);
            end
            OP_SUB: begin
                res_s      = sub_s[WIDTH-1:0];
                carry_s    = sub_s[WIDTH];
                overflow_s = sub_ovf(operand1[WIDTH-1], operand2[WIDTH-1], sub_s[WIDTH-1]);
            end
            OP_AND:  res_s = operand1 & operand2;
            OP_OR:   res_s = operand1 | operand2;
            OP_XOR:  res_s = operand1 ^ operand2;
            OP_SLL:  res_s = operand1 << shamt_s;
            OP_SRL:  res_s = operand1 >> shamt_s;
            OP_SRA:  res_s = sra_s;
            OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, sltu_s};
            default: begin
                res_s      = {WIDTH{1'b0}};
                carry_s    = 1'b0;
                overflow_s = 1'b0;
            end
        endcase
    end

    // Output register: reset wins, a valid op loads, otherwise hold with out_valid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= {WIDTH{1'b0}};
            zero      <= 1'b1;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            result    <= res_s;
            zero      <= (res_s == {WIDTH{1'b0}});
            negative  <= res_s[WIDTH-1];
            carry     <= carry_s;
            overflow  <= overflow_s;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors with hand-computed results for alu_unit.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  ALUoperation;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    alu_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .operand1(operand1), .operand2(operand2), .ALUoperation(ALUoperation),
        .out_valid(out_valid), .result(result), .zero(zero),
        .negative(negative), .carry(carry), .overflow(overflow)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one op, advance one clock, then check result, {z,n,c,v} and out_valid.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic [3:0] exp_flags);
        ALUoperation = op;
        operand1     = a;
        operand2     = b;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        check_value({tag, " result"}, result, exp_res);
        check_value({tag, " flags"}, {28'd0, zero, negative, carry, overflow}, {28'd0, exp_flags});
        check_value({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1;
        ALUoperation = 4'b0000; operand1 = 32'd10; operand2 = 32'd20;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_value("reset result", result, 32'd0);
        check_value("reset flags", {28'd0, zero, negative, carry, overflow}, 32'h8);
        check_value("reset valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;

        // flags order: {zero, negative, carry, overflow}
        run_op("add 10+20",    4'b0000, 32'd10,        32'd20,        32'd30,        4'b0000);
        run_op("sub 20-10",    4'b0001, 32'd20,        32'd10,        32'd10,        4'b0010);
        run_op("sub 10-10",    4'b0001, 32'd10,        32'd10,        32'd0,         4'b1010);
        run_op("add ffff+1",   4'b0000, 32'hFFFFFFFF,  32'd1,         32'd0,         4'b1010);
        run_op("add 7fff+1",   4'b0000, 32'h7FFFFFFF,  32'd1,         32'h80000000,  4'b0101);
        run_op("sub 8000-1",   4'b0001, 32'h80000000,  32'd1,         32'h7FFFFFFF,  4'b0011);
        run_op("sub 0-1",      4'b0001, 32'd0,         32'd1,         32'hFFFFFFFF,  4'b0100);
        run_op("and",          4'b0010, 32'hFF00FF00,  32'h00FF00FF,  32'h00000000,  4'b1000);
        run_op("or",           4'b0011, 32'hFF00FF00,  32'h00FF00FF,  32'hFFFFFFFF,  4'b0100);
        run_op("xor",          4'b0100, 32'hF0F0F0F0,  32'h0F0F0F0F,  32'hFFFFFFFF,  4'b0100);
        run_op("sll 1<<4",     4'b0101, 32'h00000001,  32'd4,         32'h00000010,  4'b0000);
        run_op("srl",          4'b0110, 32'h80000000,  32'd4,         32'h08000000,  4'b0000);
        run_op("sra",          4'b0111, 32'hF0000000,  32'd4,         32'hFF000000,  4'b0100);
        run_op("sll by 0x24",  4'b0101, 32'h00000001,  32'h24,        32'h00000010,  4'b0000);
        run_op("sra by 0",     4'b0111, 32'h80000001,  32'd0,         32'h80000001,  4'b0100);
        run_op("srl by 0x20",  4'b0110, 32'h80000001,  32'h20,        32'h80000001,  4'b0100);
        run_op("slt -5<10",    4'b1000, 32'hFFFFFFFB,  32'd10,        32'd1,         4'b0000);
        run_op("sltu fff0<10", 4'b1001, 32'hFFFFFFF0,  32'h10,        32'd0,         4'b1000);
        run_op("slt 8000<1",   4'b1000, 32'h80000000,  32'd1,         32'd1,         4'b0000);
        run_op("slt 7fff<8000",4'b1000, 32'h7FFFFFFF,  32'h80000000,  32'd0,         4'b1000);
        run_op("sltu 0<0",     4'b1001, 32'd0,         32'd0,         32'd0,         4'b1000);
        run_op("sltu 1<ffff",  4'b1001, 32'd1,         32'hFFFFFFFF,  32'd1,         4'b0000);
        run_op("rsvd 1111",    4'b1111, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         4'b1000);
        run_op("add before hold", 4'b0000, 32'h7FFFFFFF, 32'd1,       32'h80000000,  4'b0101);

        // in_valid low: outputs hold, out_valid drops
        in_valid = 1'b0; ALUoperation = 4'b0000; operand1 = 32'd1; operand2 = 32'd1;
        @(posedge clk);
        #1;
        check_value("hold result", result, 32'h80000000);
        check_value("hold flags", {28'd0, zero, negative, carry, overflow}, 32'h5);
        check_value("hold valid", {31'd0, out_valid}, 32'd0);

        run_op("rsvd 1010",    4'b1010, 32'h12345678,  32'h1,         32'd0,         4'b1000);
        run_op("add pre-rst",  4'b0000, 32'd5,         32'd6,         32'd11,        4'b0000);

        // reset with in_valid high: op discarded
        rst = 1'b1; in_valid = 1'b1; ALUoperation = 4'b0000; operand1 = 32'd100; operand2 = 32'd200;
        @(posedge clk);
        #1;
        check_value("rst+valid result", result, 32'd0);
        check_value("rst+valid flags", {28'd0, zero, negative, carry, overflow}, 32'h8);
        check_value("rst+valid valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;

        run_op("add post-rst", 4'b0000, 32'd100,       32'd200,       32'd300,       4'b0000);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_value("idle valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
